fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
//  Instruction-fetch sequencer for the IF stage. Owns the fetch PC and drives the SRAM-like instruction bus
//  (req/addr_ok/data_ok), keeping at most one request outstanding. Applies CSR/trap and branch redirects,
//  discards responses made stale by a redirect, and buffers fetched instructions in a 2-entry FIFO toward decode.
// PARAMETERS
//  PC_WIDTH    32            fetch PC / bus address width
//  INST_WIDTH  32            instruction word width
//  RESET_PC    32'h8000_0000 first fetch address after reset
// PORTS
//  clk               in   1           clock; all state updates on rising edge
//  rst               in   1           synchronous reset, active-high
//  csr_redir_valid_i in   1           trap/mret redirect request (highest priority)
//  csr_redir_pc_i    in   PC_WIDTH    trap/mret target
//  br_redir_valid_i  in   1           branch/jalr mispredict redirect
//  br_redir_pc_i     in   PC_WIDTH    branch/jalr target
//  inst_req_o        out  1           bus request
//  inst_addr_o       out  PC_WIDTH    bus address; valid while inst_req_o=1
//  inst_addr_ok_i    in   1           address accepted (meaningful only when inst_req_o=1)
//  inst_data_ok_i    in   1           read data returned for the outstanding request
//  inst_rdata_i      in   INST_WIDTH  read data
//  D_ready_i         in   1           decode consumes the FIFO head this cycle
//  F_valid_o         out  1           FIFO head valid
//  F_pc_o            out  PC_WIDTH    PC of FIFO head
//  F_instr_o         out  INST_WIDTH  instruction of FIFO head
// BEHAVIOUR
//  Reset: state=IDLE, fetch_pc=RESET_PC, FIFO count=0, inst_req_o=0, F_valid_o=0, F_pc_o=0, F_instr_o=0.
//  Redirect: redir = csr_redir_valid_i | br_redir_valid_i; target = CSR pc if CSR valid, else branch pc.
//   - Same cycle: fetch_pc<=target, FIFO flushed (count<=0); a redirect overrides any same-cycle
//     data push or pop.
//  States:
//   - IDLE:   -> REQ when count<2 (or immediately on redir).
//   - REQ:    inst_req_o = (count<2); inst_addr_o = fetch_pc.
//             - req & addr_ok & ~redir: latch req_pc=fetch_pc, fetch_pc<=fetch_pc+4, -> WAIT.
//             - req & addr_ok & redir: -> CANCEL (accepted address is stale).
//             - redir without addr_ok: stay REQ; the address changes to target next cycle
//               (legal because there was no handshake).
//   - WAIT:   inst_req_o=0.
//             - data_ok & ~redir: push {req_pc, rdata}, -> REQ.
//             - data_ok & redir: data dropped, -> REQ.
//             - redir without data_ok: -> CANCEL.
//   - CANCEL: inst_req_o=0.
//             - data_ok: discard data, -> REQ.
//             - A further redir only updates fetch_pc; the state stays CANCEL.
//  Space rule: a request is issued only when count<=1, so every push has room; a push into a full FIFO
//   is impossible and is asserted against in simulation.
//  FIFO: 2 entries, head on F_*_o, registered outputs. Pop = F_valid_o & D_ready_i.
//   - Push and pop in the same cycle: count unchanged.
//   - F_valid_o = (count!=0).
//  PC arithmetic: +4 modulo 2^PC_WIDTH; wraps silently from all-ones-minus-3 to 0.
//  Latency:
//   - Redirect in IDLE/REQ at cycle t: inst_req_o with target at t+1.
//   - data_ok at cycle t: F_valid_o with that instruction at t+1.
//  Reset mid-operation: any outstanding bus transaction is abandoned. The bus slave is reset by the same rst.
// TESTING
//  1. Reset release, addr_ok and data_ok same-cycle-after-req, D_ready=1 -> addresses 8000_0000, _0004, _0008...
//     F_pc_o follows one cycle after each data_ok.
//  2. D_ready=0 for 10 cycles -> exactly 2 instructions buffered; inst_req_o held 0 while count=2.
//     Release -> pops in order, fetching resumes.
//  3. br_redir (pc=8000_0100) in WAIT -> CANCEL; the returned data is not pushed.
//     Next req addr=8000_0100; FIFO was flushed.
//  4. csr_redir(8000_0200) and br_redir(8000_0300) in the same cycle -> next address 8000_0200.
//  5. redir in REQ with addr_ok=0 -> address switches to target next cycle, no CANCEL.
//     redir coincident with addr_ok -> CANCEL, one response discarded.
//  6. rst asserted in WAIT -> next cycle all outputs at reset values; first req addr=RESET_PC.

Source files
------------

// File: rtl/fetch_ctrl_if.sv
// Signal bundle between the fetch sequencer and its environment: redirect inputs,
// the SRAM-like instruction bus and the fetch-to-decode FIFO head.
interface fetch_ctrl_if #(
  parameter int unsigned PC_WIDTH   = 32,
  parameter int unsigned INST_WIDTH = 32
);
  logic                  csr_redir_valid_i;
  logic [PC_WIDTH-1:0]   csr_redir_pc_i;
  logic                  br_redir_valid_i;
  logic [PC_WIDTH-1:0]   br_redir_pc_i;
  logic                  inst_req_o;
  logic [PC_WIDTH-1:0]   inst_addr_o;
  logic                  inst_addr_ok_i;
  logic                  inst_data_ok_i;
  logic [INST_WIDTH-1:0] inst_rdata_i;
  logic                  D_ready_i;
  logic                  F_valid_o;
  logic [PC_WIDTH-1:0]   F_pc_o;
  logic [INST_WIDTH-1:0] F_instr_o;

  modport master (
    input  csr_redir_valid_i, csr_redir_pc_i, br_redir_valid_i, br_redir_pc_i,
    output inst_req_o, inst_addr_o,
    input  inst_addr_ok_i, inst_data_ok_i, inst_rdata_i,
    input  D_ready_i,
    output F_valid_o, F_pc_o, F_instr_o
  );

  modport slave (
    output csr_redir_valid_i, csr_redir_pc_i, br_redir_valid_i, br_redir_pc_i,
    input  inst_req_o, inst_addr_o,
    output inst_addr_ok_i, inst_data_ok_i, inst_rdata_i,
    output D_ready_i,
    input  F_valid_o, F_pc_o, F_instr_o
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: one outstanding bus request, redirect handling with stale
// response discard, and a 2-entry instruction FIFO toward decode.
module fetch_ctrl #(
  parameter int unsigned        PC_WIDTH   = 32,
  parameter int unsigned        INST_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = 32'h8000_0000
) (
  input logic          clk,
  input logic          rst,
  fetch_ctrl_if.master bus
);
  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StReq    = 2'd1;
  localparam logic [1:0] StWait   = 2'd2;
  localparam logic [1:0] StCancel = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [PC_WIDTH-1:0]   req_pc_q, req_pc_d;
  logic [1:0]            count_q;
  logic [PC_WIDTH-1:0]   head_pc_q, tail_pc_q;
  logic [INST_WIDTH-1:0] head_instr_q, tail_instr_q;

  logic                redir;
  logic [PC_WIDTH-1:0] target;
  logic                req;
  logic                push;
  logic                pop;

  assign redir  = bus.csr_redir_valid_i | bus.br_redir_valid_i;
  assign target = bus.csr_redir_valid_i ? bus.csr_redir_pc_i : bus.br_redir_pc_i;
  // Only request while a slot is guaranteed free for the response.
  assign req    = (state_q == StReq) && (count_q != 2'd2);
  assign pop    = (count_q != 2'd0) && bus.D_ready_i;

  assign bus.inst_req_o  = req;
  assign bus.inst_addr_o = pc_q;
  assign bus.F_valid_o   = (count_q != 2'd0);
  assign bus.F_pc_o      = head_pc_q;
  assign bus.F_instr_o   = head_instr_q;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    push     = 1'b0;
    case (state_q)
      StIdle: begin
        if (redir || (count_q != 2'd2)) state_d = StReq;
      end
      StReq: begin
        if (req && bus.inst_addr_ok_i) begin
          if (redir) begin
            state_d = StCancel;
          end else begin
            state_d  = StWait;
            req_pc_d = pc_q;
            pc_d     = pc_q + PC_WIDTH'(4);
          end
        end
      end
      StWait: begin
        if (bus.inst_data_ok_i) begin
          state_d = StReq;
          push    = !redir;
        end else if (redir) begin
          state_d = StCancel;
        end
      end
      StCancel: begin
        if (bus.inst_data_ok_i) state_d = StReq;
      end
      default: state_d = StIdle;
    endcase
    if (redir) pc_d = target;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end

  // Redirect flushes the FIFO and overrides any same-cycle push or pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q      <= 2'd0;
      head_pc_q    <= '0;
      head_instr_q <= '0;
      tail_pc_q    <= '0;
      tail_instr_q <= '0;
    end else if (redir) begin
      count_q <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            head_pc_q    <= req_pc_q;
            head_instr_q <= bus.inst_rdata_i;
          end else begin
            tail_pc_q    <= req_pc_q;
            tail_instr_q <= bus.inst_rdata_i;
          end
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          head_pc_q    <= tail_pc_q;
          head_instr_q <= tail_instr_q;
          count_q      <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            head_pc_q    <= req_pc_q;
            head_instr_q <= bus.inst_rdata_i;
          end else begin
            head_pc_q    <= tail_pc_q;
            head_instr_q <= tail_instr_q;
            tail_pc_q    <= req_pc_q;
            tail_instr_q <= bus.inst_rdata_i;
          end
        end
        default: ;
      endcase
    end
  end

  a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
    !(push && (count_q == 2'd2)));

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized and directed bench for fetch_ctrl against a queue-based model of the fetch
// pipeline and a bus slave that returns a known function of each accepted address.
module tb_fetch_ctrl;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_ctrl_if #(.PC_WIDTH(32), .INST_WIDTH(32)) bus ();

  fetch_ctrl #(.PC_WIDTH(32), .INST_WIDTH(32), .RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Slave/decode behaviour knobs (percent probabilities).
  int pa = 100, pd = 100, pr = 100;

  // Model: idle flag, fetch pc, outstanding kind (0 none, 1 live, 2 stale), FIFO of pcs.
  bit          m_idle;
  logic [31:0] m_pc;
  int          m_out;
  logic [31:0] m_live_pc;
  logic [31:0] m_q[$];

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {pc[15:0], pc[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic bit exp_req();
    return !m_idle && (m_out == 0) && (m_q.size() < 2);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    bit er;
    er = exp_req();
    chk("req", 32'(bus.inst_req_o), 32'(er));
    if (er) chk("addr", bus.inst_addr_o, m_pc);
    chk("f_valid", 32'(bus.F_valid_o), 32'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      chk("f_pc", bus.F_pc_o, m_q[0]);
      chk("f_instr", bus.F_instr_o, inst_of(m_q[0]));
    end
  endtask

  task automatic model_reset();
    m_idle = 1'b1;
    m_pc   = RESET_PC;
    m_out  = 0;
    m_q.delete();
  endtask

  task automatic step(input bit cv, input logic [31:0] cpc, input bit bv,
                      input logic [31:0] bpc);
    bit aok, dok, rdy, redir, req_e, pop, push;
    logic [31:0] tgt, ppc;
    req_e = exp_req();
    aok   = ($urandom_range(99) < pa);
    dok   = (m_out != 0) && ($urandom_range(99) < pd);
    rdy   = ($urandom_range(99) < pr);
    bus.csr_redir_valid_i = cv;
    bus.csr_redir_pc_i    = cpc;
    bus.br_redir_valid_i  = bv;
    bus.br_redir_pc_i     = bpc;
    bus.inst_addr_ok_i    = aok;
    bus.inst_data_ok_i    = dok;
    bus.inst_rdata_i      = (m_out == 1) ? inst_of(m_live_pc) : $urandom;
    bus.D_ready_i         = rdy;
    redir = cv | bv;
    tgt   = cv ? cpc : bpc;
    pop   = (m_q.size() != 0) && rdy;
    push  = 1'b0;
    ppc   = '0;
    if (m_idle) begin
      m_idle = 1'b0;
    end else if (m_out == 0) begin
      if (req_e && aok) begin
        if (redir) m_out = 2;
        else begin
          m_out     = 1;
          m_live_pc = m_pc;
          m_pc      = m_pc + 32'd4;
        end
      end
    end else if (dok) begin
      if (m_out == 1 && !redir) begin
        push = 1'b1;
        ppc  = m_live_pc;
      end
      m_out = 0;
    end else if (redir) begin
      m_out = 2;
    end
    if (redir) m_pc = tgt;
    if (redir) m_q.delete();
    else begin
      if (pop) void'(m_q.pop_front());
      if (push) m_q.push_back(ppc);
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0);
  endtask

  task automatic timeout(input string tag);
    total++;
    bad++;
    $error("FAIL %s: observed timeout expected event within bound", tag);
  endtask

  task automatic wait_live();
    int k = 0;
    while (m_out != 1 && k < 50) begin
      step(1'b0, '0, 1'b0, '0);
      k++;
    end
    if (m_out != 1) timeout("wait_live");
  endtask

  task automatic wait_req();
    int k = 0;
    while (!exp_req() && k < 50) begin
      step(1'b0, '0, 1'b0, '0);
      k++;
    end
    if (!exp_req()) timeout("wait_req");
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_req"}, 32'(bus.inst_req_o), 32'd0);
    chk({tag, "_valid"}, 32'(bus.F_valid_o), 32'd0);
    chk({tag, "_fpc"}, bus.F_pc_o, 32'd0);
    chk({tag, "_finstr"}, bus.F_instr_o, 32'd0);
  endtask

  initial begin
    bus.csr_redir_valid_i = 1'b0;
    bus.csr_redir_pc_i    = '0;
    bus.br_redir_valid_i  = 1'b0;
    bus.br_redir_pc_i     = '0;
    bus.inst_addr_ok_i    = 1'b0;
    bus.inst_data_ok_i    = 1'b0;
    bus.inst_rdata_i      = '0;
    bus.D_ready_i         = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;

    // Streaming fetch with an always-ready bus and decode.
    pa = 100; pd = 100; pr = 100;
    run(20);

    // Decode stalls: FIFO fills to two and requests stop, then drains in order.
    pr = 0;
    run(10);
    chk("full_valid", 32'(bus.F_valid_o), 32'd1);
    chk("full_req", 32'(bus.inst_req_o), 32'd0);
    pr = 100;
    run(10);

    // Branch redirect while waiting for data: response discarded, fetch restarts at target.
    pd = 0;
    wait_live();
    step(1'b0, '0, 1'b1, 32'h8000_0100);
    pd = 100;
    run(6);

    // Simultaneous CSR and branch redirects: CSR wins.
    step(1'b1, 32'h8000_0200, 1'b1, 32'h8000_0300);
    run(6);

    // Redirect in REQ without handshake, then coincident with the handshake.
    pa = 0;
    wait_req();
    step(1'b0, '0, 1'b1, 32'h8000_0400);
    step(1'b0, '0, 1'b0, '0);
    pa = 100;
    wait_req();
    step(1'b0, '0, 1'b1, 32'h8000_0500);
    run(8);

    // PC wraps from the top of the address space to zero.
    step(1'b1, 32'hFFFF_FFF8, 1'b0, '0);
    run(10);

    // Reset while a request is outstanding.
    pd = 0;
    wait_live();
    rst = 1'b1;
    bus.inst_data_ok_i = 1'b0;
    bus.inst_addr_ok_i = 1'b0;
    bus.csr_redir_valid_i = 1'b0;
    bus.br_redir_valid_i  = 1'b0;
    @(posedge clk);
    #1;
    check_reset_values("midrst");
    model_reset();
    rst = 1'b0;
    pd = 100;
    run(8);

    // Random traffic with occasional redirects.
    for (int i = 0; i < 3000; i++) begin
      if (i % 100 == 0) begin
        pa = $urandom_range(100);
        pd = $urandom_range(20, 100);
        pr = $urandom_range(100);
      end
      step(($urandom_range(99) < 3), {$urandom_range(32'hFFFF) , 14'd0, 2'b00},
           ($urandom_range(99) < 5), {16'h8000, $urandom_range(16'hFFFF)} & 32'hFFFF_FFFC);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
